// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Optional gshare counter indexing in the top is enabled by defining BP_GSHARE_EN.
package bp_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
      if (taken)
         return (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
      return (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: valid/tag/target per entry, combinational lookup ports,
// single registered write port used for both allocation and taken retraining.
module bp_btb #(
   parameter int IDX_BITS = 4,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:2] rd_pc,
   output logic            rd_hit,
   output logic [XLEN-1:0] rd_target,
   input  logic [XLEN-1:2] wr_pc,
   output logic            wr_hit,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_target
);

   localparam int NUM   = 1 << IDX_BITS;
   localparam int TAG_W = XLEN - IDX_BITS - 2;

   logic [NUM-1:0]   valid;
   logic [TAG_W-1:0] tag    [NUM];
   logic [XLEN-1:0]  target [NUM];

   logic [IDX_BITS-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0]    rd_tag, wr_tag;

   assign rd_idx = rd_pc[IDX_BITS+1:2];
   assign rd_tag = rd_pc[XLEN-1:IDX_BITS+2];
   assign wr_idx = wr_pc[IDX_BITS+1:2];
   assign wr_tag = wr_pc[XLEN-1:IDX_BITS+2];

   assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
   assign rd_target = target[rd_idx];
   assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid <= '0;
      else if (wr_en)
         valid[wr_idx] <= 1'b1;
   end

   // Tag/target need no reset: they are only observed behind a set valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag[wr_idx]    <= wr_tag;
         target[wr_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: BTB lookup plus 2-bit counters, trained from Execute.
// Define BP_GSHARE_EN to index the counters by PC xor global history.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 4,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] PCF,
   output logic            BranchPredictedF,
   output logic [XLEN-1:0] PredTargetF,
   input  logic            UpdateE,
   input  logic [XLEN-1:0] PCE,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            BranchPredictedE,
   output logic [31:0]     MispredictCount
);

   localparam int NUM = 1 << IDX_BITS;

   logic                lk_hit, up_hit;
   logic [XLEN-1:0]     lk_target;
   logic [IDX_BITS-1:0] lk_cidx, up_cidx;
   ctr_t                ctr_q [NUM];
   logic                unused_pc_lsbs;

   assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

   bp_btb #(.IDX_BITS(IDX_BITS), .XLEN(XLEN)) u_btb (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_pc     (PCF[XLEN-1:2]),
      .rd_hit    (lk_hit),
      .rd_target (lk_target),
      .wr_pc     (PCE[XLEN-1:2]),
      .wr_hit    (up_hit),
      .wr_en     (UpdateE && PCSrcE),
      .wr_target (PCTargetE)
   );

`ifdef BP_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   // Update indexes with the history held before this cycle's shift.
   assign lk_cidx = PCF[IDX_BITS+1:2] ^ ghr;
   assign up_cidx = PCE[IDX_BITS+1:2] ^ ghr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ghr <= '0;
      else if (UpdateE)
         ghr <= {ghr[IDX_BITS-2:0], PCSrcE};
   end
`else
   assign lk_cidx = PCF[IDX_BITS+1:2];
   assign up_cidx = PCE[IDX_BITS+1:2];
`endif

   assign BranchPredictedF = lk_hit && ctr_q[lk_cidx][1];
   assign PredTargetF      = BranchPredictedF ? lk_target : '0;

   // Not-taken outcomes never allocate; a miss that was taken starts weakly taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM; i++)
            ctr_q[i] <= CTR_WNT;
      end else if (UpdateE) begin
         if (up_hit)
            ctr_q[up_cidx] <= sat_update(ctr_q[up_cidx], PCSrcE);
         else if (PCSrcE)
            ctr_q[up_cidx] <= CTR_WT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         MispredictCount <= '0;
      else if (UpdateE && (PCSrcE != BranchPredictedE) && (MispredictCount != 32'hFFFF_FFFF))
         MispredictCount <= MispredictCount + 32'd1;
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default build) with a table-level reference model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PCF, PCE, PCTargetE, PredTargetF, MispredictCount;
   logic        UpdateE, PCSrcE, BranchPredictedE, BranchPredictedF;

   int total = 0;
   int bad   = 0;
   bit live  = 0;

   branch_predictor dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .PCF              (PCF),
      .BranchPredictedF (BranchPredictedF),
      .PredTargetF      (PredTargetF),
      .UpdateE          (UpdateE),
      .PCE              (PCE),
      .PCSrcE           (PCSrcE),
      .PCTargetE        (PCTargetE),
      .BranchPredictedE (BranchPredictedE),
      .MispredictCount  (MispredictCount)
   );

   always #5 clk = ~clk;

   // Reference model: 16 entries, index = (pc/4) mod 16, tag = pc/64.
   bit          m_valid [16];
   int unsigned m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   longint      m_mc;

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_mc = 0;
   endfunction

   function automatic void m_lookup(input logic [31:0] pc, output logic p, output logic [31:0] t);
      int i;
      i = int'((pc >> 2) % 16);
      p = m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
      t = p ? m_tgt[i] : 32'h0;
   endfunction

   function automatic void m_train(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                                   input logic bpe);
      int i;
      i = int'((pc >> 2) % 16);
      if (m_valid[i] && m_tag[i] == (pc >> 6)) begin
         if (tk) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = tg;
         end else
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else if (tk) begin
         m_valid[i] = 1; m_tag[i] = pc >> 6; m_tgt[i] = tg; m_ctr[i] = 2;
      end
      if (tk != bpe && m_mc < 64'hFFFF_FFFF) m_mc++;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else if (UpdateE) m_train(PCE, PCSrcE, PCTargetE, BranchPredictedE);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic        ep;
      logic [31:0] et;
      if (live) begin
         m_lookup(PCF, ep, et);
         chk("model_pred", {31'd0, BranchPredictedF}, {31'd0, ep});
         chk("model_tgt", PredTargetF, et);
         chk("model_mc", MispredictCount, m_mc[31:0]);
      end
   end

   // Inputs change 1 after a rising edge; results are read 1 after the next falling edge,
   // i.e. before this step's update has been applied.
   task automatic step(input logic [31:0] pcf, input logic upd, input logic [31:0] pce,
                       input logic tk, input logic [31:0] tg, input logic bpe);
      @(posedge clk); #1;
      PCF = pcf; UpdateE = upd; PCE = pce; PCSrcE = tk; PCTargetE = tg; BranchPredictedE = bpe;
      @(negedge clk); #1;
   endtask

   task automatic expect3(input string nm, input logic p, input logic [31:0] t, input logic [31:0] mc);
      chk({nm, "_pred"}, {31'd0, BranchPredictedF}, {31'd0, p});
      chk({nm, "_tgt"}, PredTargetF, t);
      chk({nm, "_mc"}, MispredictCount, mc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      PCF = 32'h100; UpdateE = 0; PCE = 0; PCSrcE = 0; PCTargetE = 0; BranchPredictedE = 0;
      m_reset();
      live = 1;
      @(negedge clk); #1;
      expect3("reset", 0, 32'h0, 32'd0);
      rst_n = 1'b1;

      step(32'h100, 1, 32'h100, 1, 32'h80, 0);  expect3("alloc_same_cycle", 0, 32'h0, 0);
      step(32'h100, 1, 32'h100, 0, 32'h0, 1);   expect3("after_alloc", 1, 32'h80, 1);
      step(32'h100, 1, 32'h100, 0, 32'h0, 1);   expect3("ctr01", 0, 32'h0, 2);
      step(32'h100, 1, 32'h100, 0, 32'h0, 1);   expect3("ctr00", 0, 32'h0, 3);
      step(32'h100, 1, 32'h100, 1, 32'h80, 0);  expect3("ctr00_sat", 0, 32'h0, 4);
      step(32'h100, 1, 32'h100, 1, 32'h80, 0);  expect3("ctr01_up", 0, 32'h0, 5);
      step(32'h100, 0, 32'h0, 0, 32'h0, 0);     expect3("ctr10_up", 1, 32'h80, 6);

      step(32'h140, 1, 32'h140, 1, 32'h300, 0); expect3("alias_miss", 0, 32'h0, 6);
      step(32'h100, 0, 32'h0, 0, 32'h0, 0);     expect3("alias_evict", 0, 32'h0, 7);
      step(32'h140, 0, 32'h0, 0, 32'h0, 0);     expect3("alias_hit", 1, 32'h300, 7);

      step(32'h200, 1, 32'h200, 1, 32'h44, 0);  expect3("nobypass", 0, 32'h0, 7);
      step(32'h200, 0, 32'h0, 0, 32'h0, 0);     expect3("bypass_next", 1, 32'h44, 8);

      step(32'h104, 1, 32'h104, 1, 32'h504, 1);
      step(32'h108, 1, 32'h108, 1, 32'h508, 1); expect3("alloc104_hit_cross", 0, 32'h0, 8);
      step(32'h10C, 1, 32'h10C, 1, 32'h50C, 1); expect3("alloc108_pending", 0, 32'h0, 8);
      step(32'h104, 1, 32'h110, 1, 32'h600, 1); expect3("pre_reset", 1, 32'h504, 8);

      rst_n = 1'b0; #1;
      expect3("async_reset", 0, 32'h0, 0);
      @(posedge clk); #1;
      PCF = 32'h10C; UpdateE = 0;
      @(negedge clk); #1;
      expect3("reset_held", 0, 32'h0, 0);
      rst_n = 1'b1;
      step(32'h110, 0, 32'h0, 0, 32'h0, 0);     expect3("reset_beat_update", 0, 32'h0, 0);
      step(32'h108, 0, 32'h0, 0, 32'h0, 0);     expect3("post_reset", 0, 32'h0, 0);
      step(32'h108, 1, 32'h108, 1, 32'h77, 0);
      step(32'h108, 0, 32'h0, 0, 32'h0, 0);     expect3("retrain", 1, 32'h77, 1);

      @(posedge clk); #1;
      live = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
